// File: rtl/seg7_disp_arbiter_pkg.sv
// Shared definitions for the SEG7 display path: FSM encodings and display word geometry.
// Imported by the arbiter and intended for the display register and scroll/blink blocks.
package seg7_disp_arbiter_pkg;

  localparam int SEG7_WORD_W = 32;
  localparam int NIBBLE_W    = 4;
  localparam int DIGITS      = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/seg7_disp_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first set request scanning ptr+1, ptr+2, ...
// modulo NUM_REQ. ptr itself has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  int w_dist;
  int w_bestDist;

  // Distance from ptr+1 in scan order; the smallest distance among set bits wins.
  always_comb begin
    sel        = '0;
    any        = 1'b0;
    w_dist     = 0;
    w_bestDist = NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dist = (k - int'(ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (req[k] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        sel        = IDX_W'(k);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin arbiter sharing the 8-digit SEG7 display word between NUM_REQ requesters,
// with a minimum on-screen hold time after every write.
module seg7_disp_arbiter
  import seg7_disp_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26,
  parameter int IDX_W       = 3
) (
  input  logic                           iCLK,
  input  logic                           iRST_N,
  input  logic [NUM_REQ-1:0]             iREQ,
  input  logic [SEG7_WORD_W*NUM_REQ-1:0] iDATA,
  output logic [NUM_REQ-1:0]             oACK,
  output logic [SEG7_WORD_W-1:0]         oDIG,
  output logic                           oWR,
  output logic [IDX_W-1:0]               oOWNER,
  output logic                           oBUSY
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NUM_REQ - 1);

  arb_state_t r_state;
  arb_state_t w_stateNxt;

  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_ptr;
  logic [SEG7_WORD_W-1:0] r_dig;
  logic                   r_wr;
  logic [NUM_REQ-1:0]     r_ack;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_busy;

  logic [CNT_W-1:0]       w_cntNxt;
  logic [IDX_W-1:0]       w_ptrNxt;
  logic [SEG7_WORD_W-1:0] w_digNxt;
  logic                   w_wrNxt;
  logic [NUM_REQ-1:0]     w_ackNxt;
  logic [IDX_W-1:0]       w_ownerNxt;
  logic                   w_busyNxt;

  logic [IDX_W-1:0]       w_sel;
  logic                   w_any;
  logic [SEG7_WORD_W-1:0] w_selWord;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (iREQ),
    .ptr (r_ptr),
    .sel (w_sel),
    .any (w_any)
  );

  always_comb begin
    w_selWord = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel == IDX_W'(k)) begin
        w_selWord = iDATA[k*SEG7_WORD_W +: SEG7_WORD_W];
      end
    end
  end

  // Requests seen during HOLD are simply not looked at; they wait for the return to IDLE.
  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = r_cnt;
    w_ptrNxt   = r_ptr;
    w_digNxt   = r_dig;
    w_wrNxt    = 1'b0;
    w_ackNxt   = '0;
    w_ownerNxt = r_owner;
    w_busyNxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_digNxt   = w_selWord;
          w_wrNxt    = 1'b1;
          for (int k = 0; k < NUM_REQ; k++) begin
            w_ackNxt[k] = (w_sel == IDX_W'(k));
          end
          w_ownerNxt = w_sel;
          w_ptrNxt   = w_sel;
          w_cntNxt   = HOLD_LOAD;
          w_busyNxt  = 1'b1;
          w_stateNxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_busyNxt  = 1'b0;
          w_stateNxt = ST_IDLE;
        end else begin
          w_cntNxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_stateNxt = ST_IDLE;
        w_busyNxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= PTR_INIT;
      r_dig   <= '0;
      r_wr    <= 1'b0;
      r_ack   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_cnt   <= w_cntNxt;
      r_ptr   <= w_ptrNxt;
      r_dig   <= w_digNxt;
      r_wr    <= w_wrNxt;
      r_ack   <= w_ackNxt;
      r_owner <= w_ownerNxt;
      r_busy  <= w_busyNxt;
    end
  end

  assign oACK   = r_ack;
  assign oDIG   = r_dig;
  assign oWR    = r_wr;
  assign oOWNER = r_owner;
  assign oBUSY  = r_busy;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with NUM_REQ=4, HOLD_CYCLES=5: a per-cycle vector
// table plus hand-written sequences for reset, full contention, mid-HOLD reset and re-grant.
module tb_seg7_disp_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int HOLD_CYCLES = 5;
  localparam int CNT_W       = 3;
  localparam int IDX_W       = 2;

  logic                 iCLK;
  logic                 iRST_N;
  logic [NUM_REQ-1:0]   iREQ;
  logic [32*NUM_REQ-1:0] iDATA;
  logic [NUM_REQ-1:0]   oACK;
  logic [31:0]          oDIG;
  logic                 oWR;
  logic [IDX_W-1:0]     oOWNER;
  logic                 oBUSY;

  logic [31:0] data [NUM_REQ];
  int nChecks;
  int nFails;

  always_comb iDATA = {data[3], data[2], data[1], data[0]};

  seg7_disp_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iREQ   (iREQ),
    .iDATA  (iDATA),
    .oACK   (oACK),
    .oDIG   (oDIG),
    .oWR    (oWR),
    .oOWNER (oOWNER),
    .oBUSY  (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [3:0]  req;
    logic        exWr;
    logic [3:0]  exAck;
    logic [31:0] exDig;
    logic [1:0]  exOwner;
    logic        exBusy;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    iREQ = req;
    tick();
  endtask

  task automatic doReset();
    iRST_N = 1'b0;
    iREQ   = '0;
    tick();
    tick();
    iRST_N = 1'b1;
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    iRST_N  = 1'b0;
    iREQ    = '0;
    data[0] = 32'h1111_0000;
    data[1] = 32'h2222_1111;
    data[2] = 32'h1234_ABCD;
    data[3] = 32'h4444_3333;

    // Single grant of requester 2 then the withdrawn-request case, one row per clock.
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 32'h1234_ABCD, 2'd2, 1'b1};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 32'h1234_ABCD, 2'd2, 1'b1};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 32'h1234_ABCD, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 32'h1234_ABCD, 2'd2, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 32'h1234_ABCD, 2'd2, 1'b1};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 32'h1234_ABCD, 2'd2, 1'b0};
    vecs[6]  = '{4'b0001, 1'b1, 4'b0001, 32'h1111_0000, 2'd0, 1'b1};
    vecs[7]  = '{4'b1000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b1};
    vecs[8]  = '{4'b1000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 32'h1111_0000, 2'd0, 1'b0};

    // Reset held with every requester asking: outputs must stay at reset values.
    iREQ = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("reset_dig",  oDIG,         32'h0);
      checkOutput("reset_wr",   32'(oWR),     32'h0);
      checkOutput("reset_ack",  32'(oACK),    32'h0);
      checkOutput("reset_busy", 32'(oBUSY),   32'h0);
      checkOutput("reset_own",  32'(oOWNER),  32'h0);
    end
    iREQ   = 4'b0000;
    iRST_N = 1'b1;
    tick();

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].req);
      checkOutput($sformatf("vec%0d_wr", v),    32'(oWR),    32'(vecs[v].exWr));
      checkOutput($sformatf("vec%0d_ack", v),   32'(oACK),   32'(vecs[v].exAck));
      checkOutput($sformatf("vec%0d_dig", v),   oDIG,        vecs[v].exDig);
      checkOutput($sformatf("vec%0d_owner", v), 32'(oOWNER), 32'(vecs[v].exOwner));
      checkOutput($sformatf("vec%0d_busy", v),  32'(oBUSY),  32'(vecs[v].exBusy));
    end

    // Full contention right after reset: grants 0,1,2,3,0 spaced HOLD_CYCLES+1 apart.
    begin
      int expOrder [5];
      int nGrants;
      int lastCycle;
      expOrder = '{0, 1, 2, 3, 0};
      nGrants  = 0;
      lastCycle = -1;
      doReset();
      iREQ = 4'b1111;
      for (int c = 0; c < 40 && nGrants < 5; c++) begin
        tick();
        if (oWR) begin
          checkOutput("rr_owner", 32'(oOWNER), 32'(expOrder[nGrants]));
          checkOutput("rr_ack",   32'(oACK),   32'(4'b0001 << expOrder[nGrants]));
          checkOutput("rr_dig",   oDIG,        data[expOrder[nGrants]]);
          if (lastCycle >= 0) checkOutput("rr_spacing", 32'(c - lastCycle), 32'(HOLD_CYCLES + 1));
          lastCycle = c;
          nGrants++;
        end
      end
      checkOutput("rr_grant_count", 32'(nGrants), 32'd5);
      iREQ = 4'b0000;
    end

    // Asynchronous reset in the middle of HOLD, then requester 0 must win first.
    doReset();
    applyStimulus(4'b0100);
    checkOutput("midrst_grant_wr", 32'(oWR), 32'h1);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    #2 iRST_N = 1'b0;
    #1;
    checkOutput("midrst_busy",  32'(oBUSY),  32'h0);
    checkOutput("midrst_dig",   oDIG,        32'h0);
    checkOutput("midrst_owner", 32'(oOWNER), 32'h0);
    tick();
    iRST_N = 1'b1;
    applyStimulus(4'b1001);
    checkOutput("midrst_first_owner", 32'(oOWNER), 32'h0);
    checkOutput("midrst_first_ack",   32'(oACK),   32'h1);
    checkOutput("midrst_first_dig",   oDIG,        32'h1111_0000);
    iREQ = 4'b0000;

    // Sole requester with a changing word: each grant shows the word present at its edge.
    begin
      int nGrants;
      int lastCycle;
      logic [31:0] prevWord;
      nGrants   = 0;
      lastCycle = -1;
      doReset();
      for (int c = 0; c < 30; c++) begin
        data[1]  = 32'hA000_0000 + 32'(c);
        prevWord = data[1];
        applyStimulus(4'b0010);
        if (oWR) begin
          checkOutput("sole_dig",   oDIG,        prevWord);
          checkOutput("sole_owner", 32'(oOWNER), 32'h1);
          if (lastCycle >= 0) checkOutput("sole_spacing", 32'(c - lastCycle), 32'(HOLD_CYCLES + 1));
          lastCycle = c;
          nGrants++;
        end
      end
      checkOutput("sole_grant_count", 32'(nGrants), 32'd5);
      iREQ = 4'b0000;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
